// File: rtl/axi_burst_sram_if.sv
// AXI-full burst bus between the data-cache master and the SRAM slave.
// One bundle carries AR/R/AW/W/B; the master/slave modports fix direction.
interface axi_burst_sram_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic [1:0]  arburst;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rlast;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic [1:0]  awburst;
  logic [7:0]  awlen;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wlast;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, arburst, arlen, arsize,
    output rready,
    output awaddr, awvalid, awburst, awlen,
    output wdata, wstrb, wvalid, wlast,
    output bready,
    input  arready, rdata, rresp, rvalid, rlast,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, arburst, arlen, arsize,
    input  rready,
    input  awaddr, awvalid, awburst, awlen,
    input  wdata, wstrb, wvalid, wlast,
    input  bready,
    output arready, rdata, rresp, rvalid, rlast,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_burst_sram.sv
// 64-bit AXI burst slave SRAM: independent read/write FSMs
// sharing one word-addressed array, parameterizable read latency.
module axi_burst_sram #(
  parameter int          DEPTH      = 4096,
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter int          READ_LAT   = 1,
  parameter bit          BRESP_WAIT = 1'b0
) (
  input logic clk,
  input logic rst,
  axi_burst_sram_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic [63:0] mem [DEPTH];

  logic        out_en;
  logic [1:0]  r_state, w_state;
  logic [31:0] r_addr, w_addr;
  logic [31:0] r_word, w_word;
  logic        r_oor, w_oor;
  logic [7:0]  r_len, r_cnt, r_nxt;
  logic [7:0]  w_len, w_cnt;
  logic [3:0]  r_lat;
  logic        r_err, r_fix;
  logic        w_err, w_fix;
  logic        r_fetch, w_hit, w_end, w_bad, w_we;
  logic [63:0] rdata_q;
  logic [1:0]  rresp_q, bresp_q;
  logic        rvalid_q, rlast_q, bvalid_q;

  assign r_word = (r_addr - MEM_BASE) >> 3;
  assign w_word = (w_addr - MEM_BASE) >> 3;
  assign r_oor  = (r_addr < MEM_BASE) || (r_word >= 32'(DEPTH));
  assign w_oor  = (w_addr < MEM_BASE) || (w_word >= 32'(DEPTH));

  assign bus.arready = out_en && (r_state == R_IDLE);
  assign bus.awready = out_en && (w_state == W_IDLE);
  assign bus.wready  = (w_state == W_DATA);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.bresp   = bresp_q;
  assign bus.bvalid  = bvalid_q;

  // fetch the first beat, or the next one as the current is taken
  assign r_fetch = (r_state == R_DATA) &&
                   (!rvalid_q || (bus.rready && !rlast_q));
  assign r_nxt   = rvalid_q ? r_cnt + 8'd1 : 8'd0;

  assign w_hit = (w_cnt + 8'd1) == w_len;
  assign w_end = bus.wlast || w_hit;
  assign w_bad = w_oor || (bus.wlast != w_hit);
  assign w_we  = (w_state == W_DATA) && bus.wvalid &&
                 !w_oor && !rst;

  always_ff @(posedge clk) begin
    if (rst) out_en <= 1'b0;
    else     out_en <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= R_IDLE;
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_lat    <= '0;
      r_err    <= 1'b0;
      r_fix    <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (bus.arvalid && bus.arready) begin
            r_addr  <= bus.araddr;
            r_len   <= (bus.arlen == 8'd0) ? 8'd1 : bus.arlen;
            r_cnt   <= '0;
            r_lat   <= '0;
            r_err   <= bus.arburst[1] || (bus.arsize != 3'd3);
            r_fix   <= (bus.arburst == 2'b00);
            r_state <= (READ_LAT == 0) ? R_DATA : R_WAIT;
          end
        end
        R_WAIT: begin
          r_lat <= r_lat + 4'd1;
          if (r_lat == 4'(READ_LAT - 1)) r_state <= R_DATA;
        end
        R_DATA: begin
          if (rvalid_q && bus.rready && rlast_q) begin
            r_state  <= R_IDLE;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
          end
          if (r_fetch) begin
            rvalid_q <= 1'b1;
            rdata_q  <= r_oor ? '0 : mem[r_word[AW-1:0]];
            rresp_q  <= (r_err || r_oor) ? SLVERR : OKAY;
            rlast_q  <= (r_nxt == r_len - 8'd1);
            r_cnt    <= r_nxt;
            r_addr   <= r_fix ? r_addr : r_addr + 32'd8;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state  <= W_IDLE;
      w_addr   <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_err    <= 1'b0;
      w_fix    <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (bus.awvalid && bus.awready) begin
            w_addr  <= bus.awaddr;
            w_len   <= (bus.awlen == 8'd0) ? 8'd1 : bus.awlen;
            w_cnt   <= '0;
            w_err   <= bus.awburst[1];
            w_fix   <= (bus.awburst == 2'b00);
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (bus.wvalid) begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= w_fix ? w_addr : w_addr + 32'd8;
            if (w_bad) w_err <= 1'b1;
            if (w_end) begin
              w_state  <= W_RESP;
              bvalid_q <= 1'b1;
              bresp_q  <= (w_err || w_bad) ? SLVERR : OKAY;
            end
          end
        end
        W_RESP: begin
          if (!BRESP_WAIT || bus.bready) begin
            w_state  <= W_IDLE;
            bvalid_q <= 1'b0;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // storage has no reset; a same-edge read sees the old word
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.wstrb[b])
          mem[w_word[AW-1:0]][b*8 +: 8] <= bus.wdata[b*8 +: 8];
      end
    end
  end
endmodule

// File: doc/axi_burst_sram.md
Name: axi_burst_sram

Overview:
- Synthesizable 64-bit-wide AXI-full burst slave memory, directly downstream of the data cache.
- Services 64B line refills (read bursts) and dirty-line writebacks (write bursts) issued by the cache's bus master.
- Read and write channels are independent FSMs that share one word-addressed storage array.
- Replaces the simulation-only slave in NPC builds that need a cycle-accurate, parameterizable-latency memory.

Parameters:
- DEPTH, 4096, number of 64-bit words in the storage array.
- MEM_BASE, 32'h8000_0000, byte address mapped to word 0.
- READ_LAT, 1, idle cycles between AR acceptance and the first rvalid (range 0..15).
- BRESP_WAIT, 0: 0 = bvalid is a one-cycle pulse and the FSM returns to idle regardless of bready; 1 = bvalid holds until bready.

Ports:
- clk input 1 clock
- rst input 1 synchronous active-high reset
- araddr input 32 read burst start byte address
- arvalid input 1 read address valid
- arburst input 2 burst type (00 FIXED, 01 INCR)
- arlen input 8 read burst length in beats
- arsize input 3 beat size code (3 = 8 bytes)
- arready output 1 read address accept
- rdata output 64 read beat data
- rresp output 2 read response (00 OKAY, 10 SLVERR)
- rvalid output 1 read beat valid
- rlast output 1 final read beat
- rready input 1 master accepts read beat
- awaddr input 32 write burst start byte address
- awvalid input 1 write address valid
- awburst input 2 burst type
- awlen input 8 write burst length in beats
- awready output 1 write address accept
- wdata input 64 write beat data
- wstrb input 8 byte enables
- wvalid input 1 write beat valid
- wlast input 1 master marks final write beat
- wready output 1 write beat accept
- bresp output 2 write response
- bvalid output 1 write response valid
- bready input 1 master accepts response

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- During rst and on the following edge:
  - all outputs are 0, except arready and awready, which are 1 from the first cycle after rst deasserts;
  - both FSMs go to idle; beat and latency counters clear;
  - storage contents are not cleared.
- Length encoding: arlen/awlen give beats directly (codebase convention, not AXI len-1). A value of 8 means 8 beats. A value of 0 is treated as 1 beat.
- Address mapping: word index = (addr - MEM_BASE) >> 3; addr[2:0] is ignored.
- Burst addressing: INCR adds 1 word per beat. FIXED holds the address for every beat.
- Error conditions:
  - arburst/awburst of 10 or 11, or arsize != 3: beats still complete as INCR, but the response is SLVERR.
  - Any beat whose word index is >= DEPTH, or whose addr < MEM_BASE, is out of range: it returns rdata = 0 with SLVERR, and a write to it is dropped.
- Read FSM states: R_IDLE -> R_WAIT -> R_DATA -> R_IDLE.
  - R_IDLE: arready = 1. On arvalid, latch the address, length and error flag. Go to R_WAIT, or to R_DATA if READ_LAT = 0.
  - R_WAIT: count READ_LAT cycles, then go to R_DATA.
  - R_DATA: rvalid = 1, rdata = mem[idx] registered. rlast = 1 only when the beat count equals len-1.
  - On rvalid & rready: advance idx and count. If it was the last beat, go to R_IDLE with arready = 1 on the next cycle.
  - While rvalid & !rready, rdata, rresp and rlast are held stable.
- Write FSM states: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready = 1. On awvalid, latch the address and length, then go to W_DATA.
  - W_DATA: wready = 1. On wvalid & wready, write each byte b where wstrb[b] = 1, then advance.
  - The burst ends on the beat carrying wlast, or on beat number len, whichever comes first.
  - If wlast and the beat count disagree, or any beat hit an error, bresp = SLVERR.
  - W_RESP: bvalid = 1. With BRESP_WAIT = 0, go to W_IDLE after one cycle. With BRESP_WAIT = 1, go to W_IDLE on bready.
- Same-word collision: a read fetch and a write commit to the same word in the same cycle returns the old data (read-before-write). The write is applied.
- Channel independence: AR and AW may be accepted in the same cycle. A new AR is not accepted until the read FSM returns to R_IDLE; the same holds for AW and W_IDLE.
- Reset mid-burst: the burst is abandoned immediately. No further rvalid/bvalid are issued. Words already written stay written.

Test Plan:
- Read latency: preload words 0..7 of MEM_BASE with 0x11..0x88. Send an INCR read at 0x8000_0000, arlen = 8, rready = 1. Required: 8 beats 0x11..0x88; first rvalid READ_LAT+1 cycles after the AR handshake; rlast only on beat 8; rresp = 00.
- Backpressure: repeat the read with rready toggling 1,0,0,1 per cycle. Required: rdata held stable while stalled; every beat delivered exactly once, in order.
- Byte-enable write: write an INCR burst at 0x8000_0040, awlen = 8, wstrb = 0x0F, wdata = 0xAAAA_BBBB_CCCC_DDDD into memory prefilled with all ones. Required: each word reads back 0xFFFF_FFFF_CCCC_DDDD; bvalid pulses 1 cycle with bresp = 00 and bready = 0 (BRESP_WAIT = 0).
- Out of range: read at MEM_BASE + DEPTH*8 - 8 with arlen = 2. Required: beat 1 returns data with OKAY; beat 2 returns 0 with SLVERR.
- wlast mismatch: write with awlen = 8 and wlast asserted on beat 4. Required: 4 words written, bresp = 10, and the FSM back in W_IDLE (awready = 1).
- Reset mid-burst: assert rst during read beat 3. Required: rvalid = 0 the next cycle; arready = 1 one cycle after rst drops; a fresh read returns correct data.
